// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared widths and the access-owner encoding for the
// data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned DMEM_AW       = 6;
  localparam int unsigned DMEM_DW       = 32;
  localparam int unsigned AGE_LIMIT_DEF = 4;

  // Which requester owns the access currently in flight at the memory.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_t;

endpackage

// File: rtl/dmem_age_counter.sv
// dmem_age_counter: saturating count of consecutive debug denials.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   inc        count one more denial (ignored once saturated)
//   clr        clear the count (wins over inc)
//   at_limit   count has reached LIMIT
module dmem_age_counter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned LIMIT = AGE_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q;

  assign at_limit = (cnt_q == CW'(LIMIT));

  // Count register, saturating at LIMIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && !at_limit) begin
      cnt_q <= CW'(cnt_q + CW'(1));
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: single-port data-memory arbiter between the MEM stage (fixed
// priority) and a debug/IO port. Read data returns one cycle after the grant
// and is steered to the requester that owned that access.
// Optional build macro DMEM_ARB_AGING_EN: after AGE_LIMIT consecutive debug
// denials the debug port is forced through ahead of the CPU.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata     MEM-stage access; cpu_rdata load data; cpu_stall
//   dbg_req/we/addr/wdata     debug access held until dbg_ack; dbg_rdata
//   mem_en/we/addr/wdata      strobe and payload to the synchronous memory
//   mem_rdata                 memory read data, one cycle after mem_en
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW        = DMEM_AW,
  parameter int unsigned DW        = DMEM_DW,
  parameter int unsigned AGE_LIMIT = AGE_LIMIT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  owner_t        owner_q, owner_d;
  logic          rd_q;
  logic [DW-1:0] cpu_rdata_q, dbg_rdata_q;
  logic          cpu_gnt, dbg_gnt, force_dbg, dbg_elig;

  // The ack cycle blocks a new debug grant, giving 2-cycle debug spacing.
  assign dbg_elig = (owner_q != OWN_DBG);

`ifdef DMEM_ARB_AGING_EN
  logic age_at_limit;

  dmem_age_counter #(
    .LIMIT (AGE_LIMIT)
  ) u_age (
    .clk      (clk),
    .rst      (rst),
    .inc      (dbg_elig & dbg_req & ~dbg_gnt),
    .clr      (dbg_gnt),
    .at_limit (age_at_limit)
  );

  assign force_dbg = age_at_limit;
`else
  logic unused_age_limit;
  assign unused_age_limit = ^AGE_LIMIT;
  assign force_dbg        = 1'b0;
`endif

  // Grant and memory mux; everything idles while reset is asserted.
  always_comb begin
    cpu_gnt   = 1'b0;
    dbg_gnt   = 1'b0;
    cpu_stall = 1'b0;
    owner_d   = OWN_NONE;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!rst) begin
      cpu_gnt   = cpu_req & ~force_dbg;
      dbg_gnt   = dbg_elig & dbg_req & (~cpu_req | force_dbg);
      cpu_stall = cpu_req & ~cpu_gnt;
      if (cpu_gnt) begin
        owner_d   = OWN_CPU;
        mem_en    = 1'b1;
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end else if (dbg_gnt) begin
        owner_d   = OWN_DBG;
        mem_en    = 1'b1;
        mem_we    = dbg_we;
        mem_addr  = dbg_addr;
        mem_wdata = dbg_wdata;
      end
    end
  end

  // Read data passes straight through in the return cycle, then is held.
  assign cpu_rdata = (owner_q == OWN_CPU && rd_q) ? mem_rdata : cpu_rdata_q;
  assign dbg_rdata = (owner_q == OWN_DBG && rd_q) ? mem_rdata : dbg_rdata_q;
  assign dbg_ack   = (owner_q == OWN_DBG);

  // Owner of the in-flight access plus the held read-data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q     <= OWN_NONE;
      rd_q        <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      owner_q     <= owner_d;
      rd_q        <= mem_en & ~mem_we;
      cpu_rdata_q <= cpu_rdata;
      dbg_rdata_q <= dbg_rdata;
    end
  end

endmodule
